// File: rtl/aes_key_sched.sv
// AES-128/192/256 key-schedule engine storing NUM_CTX expanded schedules, one word per cycle.
// Optional build macro AES_KS_EQINV_EN adds rd_inv (InvMixColumns keys for the equivalent inverse cipher).
module aes_key_sched #(
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [255:0]       key_in,
    input  logic [1:0]         key_len,
    input  logic [CTX_W-1:0]   key_ctx,
    input  logic               key_valid,
    output logic               key_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [NUM_CTX-1:0] ctx_valid,
    input  logic               rd_en,
    input  logic [CTX_W-1:0]   rd_ctx,
    input  logic [3:0]         rd_addr,
`ifdef AES_KS_EQINV_EN
    input  logic               rd_inv,
`endif
    output logic [127:0]       rd_key,
    output logic               rd_valid,
    output logic [3:0]         rd_nr
);

    localparam int CTX_N = 1 << CTX_W;
    localparam int WORDS = 60;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GEN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KS_EQINV_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [3:0]       nk_q, nk_d;
    logic [3:0]       nr_q, nr_d;
    logic [CTX_W-1:0] ctx_q, ctx_d;
    logic [5:0]       i_q, i_d;
    logic [2:0]       pos_q, pos_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [31:0]      win_q [8];
    logic [31:0]      win_d [8];
    logic [CTX_N-1:0] ctx_valid_q, ctx_valid_d;
    logic [3:0]       ctx_nr_q [CTX_N];
    logic [3:0]       ctx_nr_d [CTX_N];
    logic             err_q, err_d;
    logic [127:0]     rd_key_q, rd_key_d;
    logic [3:0]       rd_nr_q, rd_nr_d;
    logic             rd_valid_q, rd_valid_d;

    logic [31:0]      sched_mem [NUM_CTX][WORDS];

    logic [CTX_N-1:0] ctx_legal;
    logic             req_legal;
    logic             accept;
    logic [CTX_N-1:0] clr_mask;
    logic [CTX_N-1:0] vis_valid;
    logic [3:0]       req_nk;
    logic [3:0]       req_nr;
    logic [31:0]      w_prev, w_far, w_rot, w_sub, w_t, w_new;

    for (genvar g = 0; g < CTX_N; g++) begin : g_legal
        assign ctx_legal[g] = (g < NUM_CTX);
    end

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        req_nk = 4'd4;
        req_nr = 4'd10;
        case (key_len)
            2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
            2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
            default: ;
        endcase
        req_legal = (key_len != 2'd3) && ctx_legal[key_ctx];
        accept    = key_valid && (state_q == S_IDLE) && req_legal;
        clr_mask  = '0;
        if (accept) clr_mask[key_ctx] = 1'b1;
        vis_valid = ctx_valid_q & ~clr_mask;
    end

    // Window holds w[i-8]..w[i-1] with w[i-1] in slot 7.
    always_comb begin
        w_prev = win_q[7];
        w_far  = win_q[3'(4'd8 - nk_q)];
        w_rot  = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub  = sub_word(w_rot);
        if (pos_q == 3'd0)
            w_t = w_sub ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && pos_q == 3'd4)
            w_t = w_sub;
        else
            w_t = w_prev;
        w_new = w_far ^ w_t;
    end

    always_comb begin
        state_d     = state_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        ctx_d       = ctx_q;
        i_d         = i_q;
        pos_d       = pos_q;
        rcon_d      = rcon_q;
        win_d       = win_q;
        ctx_valid_d = ctx_valid_q;
        ctx_nr_d    = ctx_nr_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    nk_d              = req_nk;
                    nr_d              = req_nr;
                    ctx_d             = key_ctx;
                    ctx_nr_d[key_ctx] = req_nr;
                    for (int k = 0; k < 8; k++) win_d[k] = key_in[32*(7-k) +: 32];
                    state_d           = S_LOAD;
                end else if (key_valid) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                i_d     = {2'b00, nk_q};
                pos_d   = 3'd0;
                rcon_d  = 8'h01;
                state_d = S_GEN;
            end
            S_GEN: begin
                for (int k = 0; k < 7; k++) win_d[k] = win_q[k+1];
                win_d[7] = w_new;
                i_d      = i_q + 6'd1;
                pos_d    = ({1'b0, pos_q} == nk_q - 4'd1) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) rcon_d = xtime(rcon_q);
                if (i_q == {nr_q, 2'b11}) state_d = S_DONE;
            end
            default: begin
                ctx_valid_d[ctx_q] = 1'b1;
                state_d            = S_IDLE;
            end
        endcase
        ctx_valid_d = ctx_valid_d & ~clr_mask;
    end

    logic             rd_hit;
    logic [CTX_W-1:0] rd_ctx_c;
    logic [5:0]       rd_base;
    logic [127:0]     rd_word;

    always_comb begin
        rd_hit   = vis_valid[rd_ctx] && (rd_addr <= ctx_nr_q[rd_ctx]);
        rd_ctx_c = rd_hit ? rd_ctx : '0;
        rd_base  = rd_hit ? {rd_addr, 2'b00} : 6'd0;
        rd_word  = {sched_mem[rd_ctx_c][rd_base],         sched_mem[rd_ctx_c][rd_base + 6'd1],
                    sched_mem[rd_ctx_c][rd_base + 6'd2],  sched_mem[rd_ctx_c][rd_base + 6'd3]};
`ifdef AES_KS_EQINV_EN
        if (rd_inv && rd_addr != 4'd0 && rd_addr != ctx_nr_q[rd_ctx])
            rd_word = {inv_mix_col(rd_word[127:96]), inv_mix_col(rd_word[95:64]),
                       inv_mix_col(rd_word[63:32]),  inv_mix_col(rd_word[31:0])};
`endif
        rd_key_d   = rd_key_q;
        rd_nr_d    = rd_nr_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_key_d = rd_hit ? rd_word : 128'h0;
            rd_nr_d  = rd_hit ? ctx_nr_q[rd_ctx] : 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            ctx_q       <= '0;
            i_q         <= '0;
            pos_q       <= '0;
            rcon_q      <= 8'h01;
            win_q       <= '{default: '0};
            ctx_valid_q <= '0;
            ctx_nr_q    <= '{default: '0};
            err_q       <= 1'b0;
            rd_key_q    <= '0;
            rd_nr_q     <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            ctx_q       <= ctx_d;
            i_q         <= i_d;
            pos_q       <= pos_d;
            rcon_q      <= rcon_d;
            win_q       <= win_d;
            ctx_valid_q <= ctx_valid_d;
            ctx_nr_q    <= ctx_nr_d;
            err_q       <= err_d;
            rd_key_q    <= rd_key_d;
            rd_nr_q     <= rd_nr_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // NOTE: the schedule store is deliberately not reset; ctx_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            for (int j = 0; j < 8; j++)
                if (j < int'(nk_q)) sched_mem[ctx_q][j] <= win_q[3'(j + 8 - int'(nk_q))];
        end else if (state_q == S_GEN) begin
            sched_mem[ctx_q][i_q] <= w_new;
        end
    end

    assign key_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign ctx_valid = ctx_valid_q[NUM_CTX-1:0];
    assign rd_key    = rd_key_q;
    assign rd_nr     = rd_nr_q;
    assign rd_valid  = rd_valid_q;

endmodule
